// File: rtl/network_mac_pipe.sv
// network_mac_pipe
//   Pipelined signed multiply-accumulate with a valid/ready stream interface.
//   Each accepted beat is registered, multiplied, and then accumulated.
//   A beat with `first` loads the accumulator. Any other beat adds to it.
//   A beat with `last` produces one rounded, shifted and narrowed result.
//
//   The stage valid bits form one shift register:
//     vld_pipe[0]            : input register (operands + flags)
//     vld_pipe[1..MS-1]      : product registers
//     vld_pipe[MS]           : accumulator holds a finished (last) sum
//   followed by the output register (out_valid/dout/sat).
//   Latency: a last beat taken at edge 1 shows out_valid after edge MS+2.
//
//   The whole pipe advances only on adv = ce & ~(out_valid & ~out_ready).
//   As a result, a held result stalls everything behind it and nothing is dropped.
//
// Optional feature macro: NETWORK_MAC_SAT_EN
//   defined   : clip to the OUT_W signed range and flag sat
//   undefined : keep the low OUT_W bits, sat stays 0
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   ce                   : global clock enable
//   in_valid/in_ready    : input handshake; din0, din1, first, last ride with it
//   out_valid/out_ready  : output handshake; dout, sat ride with it
//
// Parameter constraints: MUL_STAGES >= 2, ACC_W >= A_W+B_W, ACC_W >= OUT_W.
module network_mac_pipe #(
  parameter int A_W        = 16,
  parameter int B_W        = 16,
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 0,
  parameter int MUL_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   din0,
  input  logic signed [B_W-1:0]   din1,
  input  logic                    first,
  input  logic                    last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  localparam int P_W  = A_W + B_W;
  localparam int SH_W = ACC_W + 1;   // one guard bit so the rounding add cannot wrap
  localparam int MS   = MUL_STAGES;

  // Half an output LSB. (1<<F)>>1 is zero when F==0, so no rounding then.
  localparam logic signed [SH_W-1:0] RND = (SH_W'(1) << FRAC_SHIFT) >> 1;

  logic adv;
  assign adv      = ce & ~(out_valid & ~out_ready);
  assign in_ready = adv & ~reset;

  // ---------------- pipeline state ----------------
  logic [MS:0]                 vld_pipe;
  logic [MS-1:0]               fst_pipe;
  logic [MS-1:0]               lst_pipe;
  logic signed [A_W-1:0]       a_q;
  logic signed [B_W-1:0]       b_q;
  logic [MS-1:1][P_W-1:0]      prod_pipe;
  logic signed [ACC_W-1:0]     acc;

  // ---------------- multiply ----------------
  logic signed [P_W-1:0] a_x, b_x, prod0;
  assign a_x   = P_W'(a_q);
  assign b_x   = P_W'(b_q);
  assign prod0 = a_x * b_x;

  logic signed [P_W-1:0]   prod_last;
  logic signed [ACC_W-1:0] prod_ext;
  assign prod_last = $signed(prod_pipe[MS-1]);
  assign prod_ext  = ACC_W'(prod_last);

  // ---------------- round / shift / narrow ----------------
  logic signed [SH_W-1:0]  acc_x, sum_r, shf;
  logic signed [OUT_W-1:0] nar;
  logic                    nsat;

  assign acc_x = {acc[ACC_W-1], acc};
  assign sum_r = acc_x + RND;
  assign shf   = sum_r >>> FRAC_SHIFT;

`ifdef NETWORK_MAC_SAT_EN
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  logic in_range;
  // The value fits when every bit from the OUT_W sign bit upward matches.
  assign in_range = (&shf[SH_W-1:OUT_W-1]) | ~(|shf[SH_W-1:OUT_W-1]);
  always_comb begin
    nar  = shf[OUT_W-1:0];
    nsat = 1'b0;
    if (!in_range) begin
      nar  = shf[SH_W-1] ? OUT_MIN : OUT_MAX;
      nsat = 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^shf[SH_W-1:OUT_W];
  assign nar       = shf[OUT_W-1:0];
  assign nsat      = 1'b0;
`endif

  // ---------------- sequential ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      fst_pipe  <= '0;
      lst_pipe  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      prod_pipe <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      sat       <= 1'b0;
    end else if (adv) begin
      // input register
      vld_pipe[0] <= in_valid;
      fst_pipe[0] <= first;
      lst_pipe[0] <= last;
      a_q         <= din0;
      b_q         <= din1;

      // first product register
      vld_pipe[1]  <= vld_pipe[0];
      fst_pipe[1]  <= fst_pipe[0];
      lst_pipe[1]  <= lst_pipe[0];
      prod_pipe[1] <= prod0;

      // extra product delay stages (none when MUL_STAGES == 2)
      for (int i = 2; i < MS; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        fst_pipe[i]  <= fst_pipe[i-1];
        lst_pipe[i]  <= lst_pipe[i-1];
        prod_pipe[i] <= prod_pipe[i-1];
      end

      // Accumulator. Its value is kept after a last beat, so a later
      // flagless beat continues from it.
      if (vld_pipe[MS-1])
        acc <= fst_pipe[MS-1] ? prod_ext : acc + prod_ext;
      vld_pipe[MS] <= vld_pipe[MS-1] & lst_pipe[MS-1];

      // output register; dout/sat only change when a new result lands
      out_valid <= vld_pipe[MS];
      if (vld_pipe[MS]) begin
        dout <= nar;
        sat  <= nsat;
      end
    end
  end

endmodule

// File: tb/tb_network_mac_pipe.sv
module tb_network_mac_pipe;

`ifdef NETWORK_MAC_SAT_EN
  localparam bit S = 1'b1;
`else
  localparam bit S = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, ce, in_valid, first, last, out_ready;
  logic signed [15:0] din0, din1;
  logic in_ready, out_valid, sat;
  logic signed [15:0] dout;
  logic in_ready4, out_valid4, sat4;
  logic signed [15:0] dout4;

  network_mac_pipe dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .first(first), .last(last),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .sat(sat));

  network_mac_pipe #(.FRAC_SHIFT(4)) dut4 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready4),
    .din0(din0), .din1(din1), .first(first), .last(last),
    .out_valid(out_valid4), .out_ready(out_ready), .dout(dout4), .sat(sat4));

  typedef struct { int d; bit s; int d4; bit s4; } exp_t;
  typedef struct { int a; int b; bit f; bit l; int d; bit s; int d4; bit s4; } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // scoreboard consumer: a result leaves on out_valid & out_ready at an enabled edge
  always @(negedge clk) begin
    if (!reset && ce && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", int'(dout), 99999);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dout",  int'(dout),  e.d);
        chk("sat",   int'(sat),   int'(e.s));
        chk("dout4", int'(dout4), e.d4);
        chk("sat4",  int'(sat4),  int'(e.s4));
        chk("valid4_align", int'(out_valid4), 1);
      end
    end
  end

  // drive one beat, hold until accepted; returns #1 after the accepting edge
  task automatic send(input int a, input int b, input bit f, input bit l,
                      input int d, input bit s, input int d4, input bit s4);
    bit acc = 1'b0;
    int n = 0;
    din0 = 16'(a); din1 = 16'(b); first = f; last = l; in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    else if (l) begin
      exp_t e;
      e.d = d; e.s = s; e.d4 = d4; e.s4 = s4;
      sb.push_back(e);
    end
    in_valid = 1'b0; first = 1'b0; last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic addv(input int a, input int b, input bit f, input bit l,
                      input int d, input bit s, input int d4, input bit s4);
    vec_t v;
    v.a = a; v.b = b; v.f = f; v.l = l; v.d = d; v.s = s; v.d4 = d4; v.s4 = s4;
    tbl.push_back(v);
  endtask

  initial begin
    // {a, b, first, last, dout, sat, dout(FRAC_SHIFT=4), sat}
    addv(3, -4, 1, 1, -12, 0, -1, 0);
    addv(1, 1, 1, 0, 0, 0, 0, 0);
    addv(2, 2, 0, 0, 0, 0, 0, 0);
    addv(3, 3, 0, 0, 0, 0, 0, 0);
    addv(4, 4, 0, 1, 30, 0, 2, 0);
    addv(32767, 32767, 1, 1, S ? 32767 : 1, S, S ? 32767 : -4096, S);
    addv(24, 1, 1, 1, 24, 0, 2, 0);
    addv(-24, 1, 1, 1, -24, 0, -1, 0);
    addv(-32768, -32768, 1, 1, S ? 32767 : 0, S, S ? 32767 : 0, S);
    addv(8, 1, 1, 1, 8, 0, 1, 0);
    addv(-8, 1, 1, 1, -8, 0, 0, 0);
    addv(7, 1, 1, 1, 7, 0, 0, 0);
    addv(100, 100, 1, 0, 0, 0, 0, 0);          // abandoned by the next first
    addv(5, 7, 1, 1, 35, 0, 2, 0);
    addv(1, 1, 0, 0, 0, 0, 0, 0);              // continues from retained 35
    addv(2, 2, 0, 1, 40, 0, 3, 0);
    addv(-100, 50, 1, 0, 0, 0, 0, 0);
    addv(-200, 30, 0, 1, -11000, 0, -687, 0);
    addv(200, 200, 1, 0, 0, 0, 0, 0);
    addv(200, 200, 0, 1, S ? 32767 : 14464, S, 5000, 0);
    addv(-200, 200, 1, 0, 0, 0, 0, 0);
    addv(-200, 200, 0, 1, S ? -32768 : -14464, S, -5000, 0);

    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; first = 1'b0; last = 1'b0;
    out_ready = 1'b1; din0 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // latency on an idle pipe: visible after the 4th edge counting acceptance as 1
    send(3, -4, 1, 1, -12, 0, -1, 0);
    chk("lat_e1", int'(out_valid), 0);
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lat_e%0d", k), int'(out_valid), (k == 4) ? 1 : 0);
    end
    drain();

    // table, back to back
    foreach (tbl[i])
      send(tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].l, tbl[i].d, tbl[i].s, tbl[i].d4, tbl[i].s4);
    drain();

    // backpressure: hold a result for 5 cycles while the next vector waits
    out_ready = 1'b0;
    send(6, 7, 1, 1, 42, 0, 3, 0);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("bp_valid", int'(out_valid), 1);
    end
    fork
      send(9, 9, 1, 1, 81, 0, 5, 0);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_in_ready", int'(in_ready), 0);
          chk("bp_dout_held", int'(dout), 42);
          chk("bp_valid_held", int'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // clock enable low mid-flight: everything holds, no input taken
    send(2, 3, 1, 1, 6, 0, 0, 0);
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ce_in_ready", int'(in_ready), 0);
      chk("ce_no_valid", int'(out_valid), 0);
      @(posedge clk); #1;
    end
    ce = 1'b1;
    drain();

    // reset mid-vector drops the partial sum; next vector is clean
    send(10, 10, 1, 0, 0, 0, 0, 0);
    send(10, 10, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_dout", int'(dout), 0);
    send(5, 5, 1, 1, 25, 0, 2, 0);
    drain();

    // no stray results after everything settles
    repeat (10) @(posedge clk);
    #1;
    chk("final_idle_valid", int'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
